// File: rtl/decode_stage_pipe.sv
// Instruction-decode stage: register file, opcode decode, two-word LDM sequencer,
// load-use hazard stall and ID/EX output bank. Optional macro: WB_BYPASS_EN.
module decode_stage_pipe #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int REG_CNT = 8,
    parameter int CS_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instruction,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_valid,
    input  logic              ex_memr,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CS_W-1:0]   ctrl,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] imm,
    output logic [ADDR_W-1:0] rs,
    output logic [ADDR_W-1:0] rt,
    output logic [ADDR_W-1:0] rd
);

    typedef enum logic {S_OP, S_IMM} state_t;

    localparam logic [2:0] OP_LDM = 3'b010;

    state_t state_q, state_d;

    logic [DATA_W-1:0] regs_q [REG_CNT];

    logic [2:0]        f_op;
    logic [ADDR_W-1:0] f_rs, f_rt, f_rd;
    logic [DATA_W-1:0] op1, op2;
    logic              hazard, accept;

    logic              out_valid_q, out_valid_d;
    logic [CS_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;

    logic [DATA_W-1:0] hold_rd1_q, hold_rd1_d, hold_rd2_q, hold_rd2_d;
    logic [ADDR_W-1:0] hold_rs_q, hold_rs_d, hold_rt_q, hold_rt_d, hold_rd_q, hold_rd_d;

    assign f_op = instruction[DATA_W-1 -: 3];
    assign f_rs = instruction[DATA_W-4 -: ADDR_W];
    assign f_rt = instruction[DATA_W-4-ADDR_W -: ADDR_W];
    assign f_rd = instruction[DATA_W-4-2*ADDR_W -: ADDR_W];

    function automatic logic [CS_W-1:0] decode(input logic [2:0] op, input logic f0);
        logic [CS_W-1:0] c;
        c = '0;
        case (op)
            3'b001: begin c[0] = 1'b1; c[6] = 1'b1; end
            3'b010: begin c[1] = 1'b1; c[6] = 1'b1; end
            3'b011: begin c[3] = 1'b1; c[4] = 1'b1; c[6] = 1'b1; end
            3'b100: c[2] = 1'b1;
            3'b101: c[5] = 1'b1;
            3'b110: if (f0) begin c[7] = 1'b1; c[6] = 1'b1; end
                    else    c[8] = 1'b1;
            3'b111: if (f0) begin c[9] = 1'b1; c[10] = 1'b1; c[2] = 1'b1; end
                    else    begin c[9] = 1'b1; c[3] = 1'b1; c[4] = 1'b1; c[6] = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        op1 = (int'(f_rs) < REG_CNT) ? regs_q[f_rs] : '0;
        op2 = (int'(f_rt) < REG_CNT) ? regs_q[f_rt] : '0;
`ifdef WB_BYPASS_EN
        // Same-cycle writeback wins over the stale array value
        if (wb_en && wb_addr == f_rs) op1 = wb_data;
        if (wb_en && wb_addr == f_rt) op2 = wb_data;
`endif
    end

    assign hazard   = (state_q == S_OP) && in_valid && ex_valid && ex_memr &&
                      (ex_rd == f_rs || ex_rd == f_rt);
    assign in_ready = !ex_stall && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        ctrl_d      = '0;
        rd1_d       = '0;
        rd2_d       = '0;
        imm_d       = '0;
        rs_d        = '0;
        rt_d        = '0;
        rd_d        = '0;
        hold_rd1_d  = hold_rd1_q;
        hold_rd2_d  = hold_rd2_q;
        hold_rs_d   = hold_rs_q;
        hold_rt_d   = hold_rt_q;
        hold_rd_d   = hold_rd_q;
        if (flush) begin
            state_d    = S_OP;
            hold_rd1_d = '0;
            hold_rd2_d = '0;
            hold_rs_d  = '0;
            hold_rt_d  = '0;
            hold_rd_d  = '0;
        end else if (ex_stall) begin
            out_valid_d = out_valid_q;
            ctrl_d      = ctrl_q;
            rd1_d       = rd1_q;
            rd2_d       = rd2_q;
            imm_d       = imm_q;
            rs_d        = rs_q;
            rt_d        = rt_q;
            rd_d        = rd_q;
        end else if (accept) begin
            if (state_q == S_IMM) begin
                // Second LDM word is data, never decoded
                state_d     = S_OP;
                out_valid_d = 1'b1;
                ctrl_d      = decode(OP_LDM, 1'b0);
                rd1_d       = hold_rd1_q;
                rd2_d       = hold_rd2_q;
                imm_d       = instruction;
                rs_d        = hold_rs_q;
                rt_d        = hold_rt_q;
                rd_d        = hold_rd_q;
            end else if (f_op == OP_LDM) begin
                state_d    = S_IMM;
                hold_rd1_d = op1;
                hold_rd2_d = op2;
                hold_rs_d  = f_rs;
                hold_rt_d  = f_rt;
                hold_rd_d  = f_rd;
            end else begin
                out_valid_d = 1'b1;
                ctrl_d      = decode(f_op, instruction[0]);
                rd1_d       = op1;
                rd2_d       = op2;
                rs_d        = f_rs;
                rt_d        = f_rt;
                rd_d        = f_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
        end else if (wb_en && int'(wb_addr) < REG_CNT) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OP;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            hold_rd1_q  <= '0;
            hold_rd2_q  <= '0;
            hold_rs_q   <= '0;
            hold_rt_q   <= '0;
            hold_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            hold_rd1_q  <= hold_rd1_d;
            hold_rd2_q  <= hold_rd2_d;
            hold_rs_q   <= hold_rs_d;
            hold_rt_q   <= hold_rt_d;
            hold_rd_q   <= hold_rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ctrl      = ctrl_q;
    assign rd1       = rd1_q;
    assign rd2       = rd2_q;
    assign imm       = imm_q;
    assign rs        = rs_q;
    assign rt        = rt_q;
    assign rd        = rd_q;

endmodule
